// File: rtl/multdiv_ctrl.sv
// Sequencer for the iterative multiply/divide unit. Takes a start pulse
// from decode, drives the load/step enables of the datapath registers,
// stalls the pipeline while busy and returns a one-cycle ready pulse with a
// divide-by-zero flag. All outputs decode from registered state only.
module multdiv_ctrl #(
   parameter int unsigned ITER  = 32,
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             ctrl_mult,
   input  logic             ctrl_div,
   input  logic             divisor_zero,
   input  logic             abort,
   output logic             load_en,
   output logic             step_en,
   output logic [CNT_W-1:0] count,
   output logic             is_div,
   output logic             stall,
   output logic             result_rdy,
   output logic             exception
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StLoad = 2'd1;
   localparam logic [1:0] StRun  = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(ITER - 1);
   localparam logic [CNT_W-1:0] OneCnt  = CNT_W'(1);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_nxt;
   logic             r_is_div;
   logic             w_is_div_nxt;
   logic             r_dz;
   logic             w_dz_nxt;
   logic             w_is_div_start;

   // Multiply wins when both start requests arrive together.
   assign w_is_div_start = ctrl_div & ~ctrl_mult;

   // Next-state, iteration counter and operation-type latch.
   always_comb begin
      w_state_nxt  = r_state;
      w_count_nxt  = r_count;
      w_is_div_nxt = r_is_div;
      w_dz_nxt     = r_dz;
      case (r_state)
         StIdle: begin
            w_count_nxt = '0;
            if (ctrl_mult | ctrl_div) begin
               w_state_nxt  = StLoad;
               w_is_div_nxt = w_is_div_start;
               w_dz_nxt     = divisor_zero & w_is_div_start;
            end
         end
         StLoad: begin
            w_count_nxt = '0;
            if (abort) begin
               w_state_nxt  = StIdle;
               w_is_div_nxt = 1'b0;
               w_dz_nxt     = 1'b0;
            end else begin
               // Divide-by-zero skips the iterations entirely.
               w_state_nxt = r_dz ? StDone : StRun;
            end
         end
         StRun: begin
            if (abort) begin
               w_state_nxt  = StIdle;
               w_count_nxt  = '0;
               w_is_div_nxt = 1'b0;
               w_dz_nxt     = 1'b0;
            end else if (r_count == LastCnt) begin
               w_state_nxt = StDone;
               w_count_nxt = '0;
            end else begin
               w_count_nxt = r_count + OneCnt;
            end
         end
         default: begin
            // Completion cycle: abort and new starts are ignored here.
            w_state_nxt  = StIdle;
            w_count_nxt  = '0;
            w_is_div_nxt = 1'b0;
            w_dz_nxt     = 1'b0;
         end
      endcase
   end

   // State registers with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         r_state  <= StIdle;
         r_count  <= '0;
         r_is_div <= 1'b0;
         r_dz     <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_count  <= w_count_nxt;
         r_is_div <= w_is_div_nxt;
         r_dz     <= w_dz_nxt;
      end
   end

   assign load_en    = (r_state == StLoad);
   assign step_en    = (r_state == StRun);
   assign stall      = (r_state == StLoad) | (r_state == StRun);
   assign result_rdy = (r_state == StDone);
   assign exception  = (r_state == StDone) & r_dz;
   assign count      = r_count;
   assign is_div     = r_is_div;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: a table of whole-operation vectors with
// hand-computed cycle counts, plus a hand-written mid-operation reset case.
module tb_multdiv_ctrl;

   localparam int ITER  = 32;
   localparam int CNT_W = 5;
   localparam int WIN   = 40;

   logic             clk = 1'b0;
   logic             clr_n;
   logic             ctrl_mult;
   logic             ctrl_div;
   logic             divisor_zero;
   logic             abort;
   logic             load_en;
   logic             step_en;
   logic [CNT_W-1:0] count;
   logic             is_div;
   logic             stall;
   logic             result_rdy;
   logic             exception;

   int n_vec = 0;
   int n_err = 0;

   multdiv_ctrl #(.ITER(ITER), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .clr_n        (clr_n),
      .ctrl_mult    (ctrl_mult),
      .ctrl_div     (ctrl_div),
      .divisor_zero (divisor_zero),
      .abort        (abort),
      .load_en      (load_en),
      .step_en      (step_en),
      .count        (count),
      .is_div       (is_div),
      .stall        (stall),
      .result_rdy   (result_rdy),
      .exception    (exception)
   );

   always #5 clk = ~clk;

   typedef struct {
      string name;
      bit    mult;
      bit    div;
      bit    dz;
      int    abort_cnt;  // assert abort while RUN shows this count (-1 = never)
      int    poke_cnt;   // pulse ctrl_div while RUN shows this count (-1 = never)
      bit    poke_done;  // pulse ctrl_div during the DONE cycle
      int    exp_load;
      int    exp_step;
      int    exp_stall;
      int    exp_rdy_k;  // cycle after start edge holding result_rdy (0 = none)
      int    exp_exc;
      bit    exp_isdiv;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int outs_packed();
      return {25'd0, load_en, step_en, stall, result_rdy, exception, is_div} | (int'(count) << 8);
   endfunction

   task automatic run_vec(input vec_t v);
      int nload = 0;
      int nstep = 0;
      int nstall = 0;
      int nrdy = 0;
      int rdy_k = 0;
      int exc_rdy = 0;
      int seq_ok = 1;
      int isdiv_ok = 1;
      int exc_ok = 1;
      @(negedge clk);
      ctrl_mult    = v.mult;
      ctrl_div     = v.div;
      divisor_zero = v.dz;
      @(posedge clk);
      for (int k = 1; k <= WIN; k++) begin
         @(negedge clk);
         ctrl_mult    = 1'b0;
         ctrl_div     = 1'b0;
         divisor_zero = 1'b0;
         abort        = 1'b0;
         if (load_en) nload++;
         if (step_en) begin
            if (int'(count) != nstep) seq_ok = 0;
            nstep++;
         end else if (count != '0) begin
            seq_ok = 0;
         end
         if (stall) nstall++;
         if (result_rdy) begin
            nrdy++;
            if (rdy_k == 0) rdy_k = k;
            exc_rdy = int'(exception);
         end else if (exception) begin
            exc_ok = 0;
         end
         if ((load_en | step_en | result_rdy) ? (is_div != v.exp_isdiv) : is_div) isdiv_ok = 0;
         if (step_en && int'(count) == v.abort_cnt) abort = 1'b1;
         if (step_en && int'(count) == v.poke_cnt) ctrl_div = 1'b1;
         if (result_rdy && v.poke_done) ctrl_div = 1'b1;
      end
      check({v.name, ".load_cycles"}, nload, v.exp_load);
      check({v.name, ".step_cycles"}, nstep, v.exp_step);
      check({v.name, ".stall_cycles"}, nstall, v.exp_stall);
      check({v.name, ".rdy_pulses"}, nrdy, (v.exp_rdy_k != 0) ? 1 : 0);
      check({v.name, ".rdy_cycle"}, rdy_k, v.exp_rdy_k);
      check({v.name, ".exception_at_rdy"}, exc_rdy, v.exp_exc);
      check({v.name, ".exception_only_with_rdy"}, exc_ok, 1);
      check({v.name, ".count_sequence"}, seq_ok, 1);
      check({v.name, ".is_div_track"}, isdiv_ok, 1);
      check({v.name, ".idle_at_end"}, int'({stall, count}), 0);
   endtask

   initial begin
      int nload;
      int nrdy;
      int reached;

      vecs[0] = '{"mult",       1, 0, 0, -1, -1, 0, 1, 32, 33, 34, 0, 0};
      vecs[1] = '{"div_zero",   0, 1, 1, -1, -1, 0, 1,  0,  1,  2, 1, 1};
      vecs[2] = '{"both",       1, 1, 1, -1, -1, 0, 1, 32, 33, 34, 0, 0};
      vecs[3] = '{"div",        0, 1, 0, -1, -1, 0, 1, 32, 33, 34, 0, 1};
      vecs[4] = '{"div_poked",  0, 1, 0, -1, 10, 1, 1, 32, 33, 34, 0, 1};
      vecs[5] = '{"abort15",    1, 0, 0, 15, -1, 0, 1, 16, 17,  0, 0, 0};
      vecs[6] = '{"mult_again", 1, 0, 0, -1, -1, 0, 1, 32, 33, 34, 0, 0};

      clr_n        = 1'b0;
      ctrl_mult    = 1'b0;
      ctrl_div     = 1'b0;
      divisor_zero = 1'b0;
      abort        = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", outs_packed(), 0);
      clr_n = 1'b1;

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Mid-run reset at count 20 with a simultaneous ctrl_mult.
      @(negedge clk);
      ctrl_mult = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ctrl_mult = 1'b0;
      reached = 0;
      for (int k = 0; k < WIN && reached == 0; k++) begin
         if (step_en && count == 5'd20) reached = 1;
         else @(negedge clk);
      end
      check("reset_reach_count20", reached, 1);
      clr_n     = 1'b0;
      ctrl_mult = 1'b1;
      @(negedge clk);
      check("reset_mid_outputs", outs_packed(), 0);
      clr_n     = 1'b1;
      ctrl_mult = 1'b0;
      nload = 0;
      nrdy  = 0;
      for (int k = 0; k < WIN; k++) begin
         @(negedge clk);
         if (load_en) nload++;
         if (result_rdy) nrdy++;
      end
      check("reset_mult_not_accepted", nload, 0);
      check("reset_no_rdy", nrdy, 0);
      check("reset_idle_after", int'({stall, count}), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
